// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Tomasulo common data bus.
// One combinational grant per cycle; the winner is broadcast from a register.
module cdb_arbiter #(
  parameter int NREQ  = 4,
  parameter int TAGW  = 3,
  parameter int DATAW = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stall,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*TAGW-1:0]  i_req_tag,
  input  logic [NREQ*DATAW-1:0] i_req_data,
  output logic [NREQ-1:0]       o_grant,
  output logic                  o_cdb_valid,
  output logic [TAGW-1:0]       o_cdb_tag,
  output logic [DATAW-1:0]      o_cdb_data,
  output logic [15:0]           o_bcast_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    r_ptr;
  logic             r_cdb_valid;
  logic [TAGW-1:0]  r_cdb_tag;
  logic [DATAW-1:0] r_cdb_data;
  logic [15:0]      r_bcast_count;

  logic [TAGW-1:0]  w_tags  [NREQ];
  logic [DATAW-1:0] w_datas [NREQ];
  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_next_ptr;
  logic [PW-1:0]    w_idx;
  logic [PW:0]      w_sum;
  logic [TAGW-1:0]  w_tag;
  logic [DATAW-1:0] w_data;
  logic             w_any;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_tags[g]  = i_req_tag[g*TAGW +: TAGW];
    assign w_datas[g] = i_req_data[g*DATAW +: DATAW];
  end

  // Scan from the pointer, wrapping modulo NREQ; first asserted wins.
  always_comb begin
    w_grant    = '0;
    w_next_ptr = r_ptr;
    w_tag      = '0;
    w_data     = '0;
    w_any      = 1'b0;
    w_idx      = '0;
    w_sum      = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) begin
        w_sum = w_sum - (PW+1)'(NREQ);
      end
      w_idx = w_sum[PW-1:0];
      if (!i_rst && !i_stall && !w_any && i_req[w_idx]) begin
        w_any          = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_tag          = w_tags[w_idx];
        w_data         = w_datas[w_idx];
        if (w_idx == PW'(NREQ-1)) begin
          w_next_ptr = '0;
        end else begin
          w_next_ptr = w_idx + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr         <= '0;
      r_cdb_valid   <= 1'b0;
      r_cdb_tag     <= '0;
      r_cdb_data    <= '0;
      r_bcast_count <= '0;
    end else if (w_any) begin
      r_ptr         <= w_next_ptr;
      r_cdb_valid   <= 1'b1;
      r_cdb_tag     <= w_tag;
      r_cdb_data    <= w_data;
      r_bcast_count <= r_bcast_count + 16'd1;
    end else begin
      r_cdb_valid   <= 1'b0;
    end
  end

  assign o_grant       = w_grant;
  assign o_cdb_valid   = r_cdb_valid;
  assign o_cdb_tag     = r_cdb_tag;
  assign o_cdb_data    = r_cdb_data;
  assign o_bcast_count = r_bcast_count;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus random traffic
// against a rotating-priority reference model.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 3;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic [N-1:0]    req;
  logic [N*TW-1:0] tag;
  logic [N*DW-1:0] data;
  logic [N-1:0]    grant;
  logic            cvalid;
  logic [TW-1:0]   ctag;
  logic [DW-1:0]   cdata;
  logic [15:0]     ccount;

  cdb_arbiter #(.NREQ(N), .TAGW(TW), .DATAW(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall),
    .i_req(req), .i_req_tag(tag), .i_req_data(data),
    .o_grant(grant), .o_cdb_valid(cvalid), .o_cdb_tag(ctag),
    .o_cdb_data(cdata), .o_bcast_count(ccount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [TW-1:0] t;
    logic [DW-1:0] d;
    int            c;
  } exp_t;
  exp_t q[$];

  int m_ptr = 0;
  int m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: first requester in order ptr, ptr+1, ... (mod N).
  function automatic int pick();
    if (rst || stall) return -1;
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Check grant just before the edge, record expected broadcast,
  // then return shortly after the edge so the caller can change inputs.
  task automatic step(output int g);
    exp_t e;
    logic [N-1:0] eg;
    @(negedge clk);
    g  = pick();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("grant", 32'(grant), 32'(eg));
    if (g >= 0) begin
      e.t   = tag[g*TW +: TW];
      e.d   = data[g*DW +: DW];
      m_cnt = (m_cnt + 1) % 65536;
      e.c   = m_cnt;
      q.push_back(e);
      m_ptr = (g + 1) % N;
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: every broadcast must match the next scoreboard entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cdb_valid", 32'(cvalid), 32'd1);
        chk("cdb_tag", 32'(ctag), 32'(e.t));
        chk("cdb_data", 32'(cdata), 32'(e.d));
        chk("bcast_count", 32'(ccount), 32'(e.c));
      end else begin
        chk("cdb_idle", 32'(cvalid), 32'd0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(cvalid), 32'd0);
    chk("rst_tag", 32'(ctag), 32'd0);
    chk("rst_data", 32'(cdata), 32'd0);
    chk("rst_count", 32'(ccount), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    q.delete();
    m_ptr = 0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  int g;
  int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [N-1:0] pend;

  initial begin
    rst   = 1'b0;
    stall = 1'b0;
    req   = '0;
    tag   = '0;
    data  = '0;
    @(posedge clk);
    #2;
    do_reset();

    // Single requester
    req = 4'b0100;
    tag[2*TW +: TW]  = 3'd5;
    data[2*DW +: DW] = 16'h1234;
    step(g);
    chk("single_g", 32'(g), 32'd2);
    chk("single_tag", 32'(ctag), 32'd5);
    chk("single_data", 32'(cdata), 32'h1234);
    chk("single_cnt", 32'(ccount), 32'd1);

    // Skip and wrap from pointer 3
    req = 4'b0011;
    tag[0 +: TW]  = 3'd0;
    data[0 +: DW] = 16'hA000;
    tag[TW +: TW] = 3'd7;
    data[DW +: DW] = 16'hB111;
    step(g);
    chk("wrap_g0", 32'(g), 32'd0);
    req = 4'b0010;
    step(g);
    chk("wrap_g1", 32'(g), 32'd1);
    req = 4'b1111;
    step(g);
    chk("ptr_is_2", 32'(g), 32'd2);
    step(g);
    chk("cnt5", 32'(ccount), 32'd5);

    // Mid-cycle reset with a broadcast in flight
    chk("pre_rst_valid", 32'(cvalid), 32'd1);
    #2;
    do_reset();
    req = '0;
    for (int i = 0; i < 10; i++) begin
      step(g);
      chk("idle_valid", 32'(cvalid), 32'd0);
    end

    // Round-robin fairness
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      tag[i*TW +: TW]  = TW'(i + 1);
      data[i*DW +: DW] = DW'(16'hC000 + i);
    end
    for (int i = 0; i < 8; i++) begin
      step(g);
      chk("rr_order", 32'(g), 32'(order[i]));
      chk("rr_valid", 32'(cvalid), 32'd1);
    end
    req = '0;
    step(g);
    chk("rr_tail", 32'(cvalid), 32'd0);

    // Stall holds the pending request
    req = 4'b0010;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(g);
      chk("stall_valid", 32'(cvalid), 32'd0);
    end
    stall = 1'b0;
    step(g);
    chk("unstall_g", 32'(g), 32'd1);
    chk("unstall_tag", 32'(ctag), 32'd2);
    req = '0;

    // Random traffic with the requester handshake
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(99) < 15);
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(1) == 1) begin
            pend[i] = 1'b1;
            tag[i*TW +: TW]  = TW'($urandom);
            data[i*DW +: DW] = DW'($urandom);
          end
        end else if ($urandom_range(99) < 10) begin
          pend[i] = 1'b0;
        end
      end
      req = pend;
      step(g);
      if (g >= 0) pend[g] = 1'b0;
    end
    req = '0;
    stall = 1'b0;
    step(g);

    // Counter wrap
    #2;
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 65537; i++) begin
      data[0 +: DW] = DW'(i);
      step(g);
    end
    chk("wrap_count", 32'(ccount), 32'd1);
    req = '0;
    step(g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the Tomasulo Common Data Bus (CDB). It sits between the reservation-station/functional-unit result ports and the single CDB that feeds the register status table and all reservation stations. Each cycle it grants at most one pending result. The granted tag and data are broadcast from a registered CDB output on the following cycle.

## Interface
- NREQ, 4: number of result requesters (functional units); allowed range 2..8.
- TAGW, 3: width of a reservation-station tag.
- DATAW, 16: width of a result value.

- Clock  in  1  system clock, rising edge active.
- Reset  in  1  asynchronous, active-high reset.
- Stall  in  1  when 1, no grant is issued this cycle.
- Req  in  NREQ  per-requester result-valid; bit i belongs to requester i.
- ReqTag  in  NREQ*TAGW  packed tags; requester i uses bits [i*TAGW +: TAGW].
- ReqData  in  NREQ*DATAW  packed results; requester i uses bits [i*DATAW +: DATAW].
- Grant  out  NREQ  one-hot or zero, combinational; bit i=1 means requester i's payload is taken at this rising edge.
- CdbValid  out  1  registered broadcast strobe.
- CdbTag  out  TAGW  registered broadcast tag.
- CdbData  out  DATAW  registered broadcast value.
- BcastCount  out  16  number of broadcasts since reset; wraps.

## Operation
- State consists of:
  - the priority pointer Ptr (range 0..NREQ-1);
  - the CDB output register (CdbValid, CdbTag, CdbData);
  - BcastCount.
- Grant rule:
  - The arbiter scans requesters Ptr, Ptr+1, …, NREQ-1, 0, …, Ptr-1.
  - The first i with Req[i]=1 gets Grant[i]=1.
  - Grant=0 when Stall=1, Reset=1, or Req=0.
- Requester handshake:
  - Requester i raises Req[i] and holds ReqTag/ReqData stable until it samples Grant[i]=1 at a rising edge.
  - At that edge, ownership of the payload transfers to the arbiter.
  - The requester may drop Req[i] or present a new result in the next cycle.
  - Deasserting Req[i] before it is granted is allowed; that result is simply never broadcast.
- On a rising edge with a grant to requester g:
  - CdbValid<=1, CdbTag<=tag of g, CdbData<=data of g.
  - Ptr<=(g+1) mod NREQ.
  - BcastCount<=BcastCount+1; it wraps from 16'hFFFF to 0.
- On a rising edge with no grant:
  - CdbValid<=0.
  - CdbTag and CdbData hold their last values.
  - Ptr and BcastCount are unchanged.
- A requester that stays asserted is granted within NREQ grant cycles (no starvation). Stall cycles do not count toward this bound.
- Tag value 0 is broadcast like any other tag. Tag meaning is the consumer's concern.
- Stall together with pending requests: nothing is granted and all Req stay pending. Ptr does not move, so priority order is preserved across the stall.

## Timing
- Reset values: Ptr=0, CdbValid=0, CdbTag=0, CdbData=0, BcastCount=0, Grant=0.
- Reset takes effect immediately when asserted, including mid-broadcast.
  - A CdbValid pulse in flight is cleared.
  - A result granted in the same cycle that Reset rises is lost.
- Latency: a result that is granted at edge N appears on the CDB (CdbValid=1) from edge N until edge N+1. Latency is 1 cycle from grant.
- CdbValid is high for exactly one cycle per grant. Back-to-back grants keep CdbValid high continuously, with a new tag every cycle.
- Throughput: one broadcast per cycle when any Req is set and Stall=0.
- Grant is purely combinational from Req, Stall, Reset and Ptr. It has no dependency on CdbValid.

## Test plan
- Reset/idle:
  - Stimulus: assert Reset mid-cycle with CdbValid=1 and BcastCount=5.
  - Required: all outputs go to 0 immediately, with no clock edge needed.
  - Required: after release with Req=0, CdbValid stays 0 for 10 cycles.
- Single requester:
  - Stimulus: Req=4'b0100, ReqTag for unit 2 = 3'd5, ReqData for unit 2 = 16'h1234, held for one grant.
  - Required: Grant=4'b0100.
  - Required: the next cycle shows CdbValid=1, CdbTag=5, CdbData=16'h1234.
  - Required: Ptr becomes 3 and BcastCount becomes 1.
- Round-robin fairness:
  - Stimulus: from reset, hold Req=4'b1111 for 8 cycles.
  - Required grant order: 0,1,2,3,0,1,2,3.
  - Required: CdbValid is continuously high from the edge of the first grant until one cycle after the last grant.
- Skip and wrap:
  - Stimulus: Ptr=3 and Req=4'b0011.
  - Required: unit 0 is granted, then unit 1.
  - Required: Ptr ends at 2.
- Stall:
  - Stimulus: Req=4'b0010, Stall=1 for 3 cycles, then Stall=0.
  - Required: Grant=0 and CdbValid=0 while Stall=1.
  - Required: unit 1 is granted in the first unstalled cycle, and its payload is broadcast on the following cycle.
- Counter wrap:
  - Stimulus: drive 65537 single grants.
  - Required: BcastCount reads 1.
